// File: rtl/mul_share_arb_pkg.sv
// mul_share_arb_pkg
//   Types and constants shared by the two-channel multiplier arbiter.
//   OP_W   : operand width (two's complement)
//   PROD_W : product width (full signed product, no truncation)
//   CNT_W  : completed-response counter width
//   state_t: arbiter FSM encoding (IDLE / MUL / RESP)
//   sat_inc: saturating increment for the response counter
package mul_share_arb_pkg;

   localparam int OP_W   = 16;
   localparam int PROD_W = 32;
   localparam int CNT_W  = 16;
   localparam int N_CH   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } state_t;

   // Holds at all-ones instead of wrapping to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mul_tc_16_16.sv
// mul_tc_16_16
//   Purely combinational signed 16x16 -> 32 multiplier.
//   a, b    : two's-complement operands
//   product : exact two's-complement product
module mul_tc_16_16
   import mul_share_arb_pkg::*;
(
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [PROD_W-1:0] product
);

   // Both operands are signed, so they are sign-extended to the 32-bit
   // result width before multiplying; the low 32 bits are the exact product.
   assign product = $signed(a) * $signed(b);

endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb
//   Two requesters share one combinational signed multiplier. A request is
//   accepted in IDLE, the product is registered in MUL, and it is held for
//   the owning channel in RESP until that channel takes it.
//   clk, rst_n                : clock, asynchronous active-low reset
//   reqN_valid/reqN_ready     : operand handshake per channel
//   reqN_a, reqN_b            : signed operands per channel
//   rspN_valid/rspN_ready     : product handshake per channel
//   rsp_product               : registered product, shared by both channels
//   busy                      : high whenever the FSM is not in IDLE
//   op_count                  : saturating count of delivered responses
module mul_share_arb
   import mul_share_arb_pkg::*;
#(
   parameter bit FIRST_CH = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_a,
   input  logic [OP_W-1:0]   req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_a,
   input  logic [OP_W-1:0]   req1_b,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [PROD_W-1:0] rsp_product,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   state_t              state;
   logic [OP_W-1:0]     op_a;
   logic [OP_W-1:0]     op_b;
   logic [PROD_W-1:0]   prod_q;
   logic [PROD_W-1:0]   mul_p;
   logic                id_q;
   logic                last_grant;
   logic [CNT_W-1:0]    op_count_q;

   // Per-channel views so the capture and decode logic can be indexed by id.
   logic [N_CH-1:0]     req_valid_v;
   logic [N_CH-1:0]     req_ready_v;
   logic [N_CH-1:0]     rsp_ready_v;
   logic [N_CH-1:0]     rsp_valid_v;
   logic [OP_W-1:0]     req_a_v [N_CH];
   logic [OP_W-1:0]     req_b_v [N_CH];

   logic                any_req;
   logic                gnt_id;
   logic                rsp_take;

   assign req_valid_v = {req1_valid, req0_valid};
   assign rsp_ready_v = {rsp1_ready, rsp0_ready};
   assign req_a_v[0]  = req0_a;
   assign req_a_v[1]  = req1_a;
   assign req_b_v[0]  = req0_b;
   assign req_b_v[1]  = req1_b;

   // A lone requester wins; on contention the channel not granted last wins.
   assign any_req = |req_valid_v;
   assign gnt_id  = (&req_valid_v) ? ~last_grant : req_valid_v[1];

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         assign req_ready_v[gi] = (state == IDLE) && any_req && (gnt_id == 1'(gi));
         assign rsp_valid_v[gi] = (state == RESP) && (id_q == 1'(gi));
      end
   endgenerate

   assign req0_ready  = req_ready_v[0];
   assign req1_ready  = req_ready_v[1];
   assign rsp0_valid  = rsp_valid_v[0];
   assign rsp1_valid  = rsp_valid_v[1];
   assign rsp_product = prod_q;
   assign busy        = (state != IDLE);
   assign op_count    = op_count_q;

   // Only the owning channel's ready can complete a response.
   assign rsp_take = rsp_ready_v[id_q];

   mul_tc_16_16 u_mul (
      .a       (op_a),
      .b       (op_b),
      .product (mul_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         op_a       <= '0;
         op_b       <= '0;
         prod_q     <= '0;
         id_q       <= 1'b0;
         op_count_q <= '0;
         last_grant <= ~FIRST_CH;
      end else begin
         case (state)
            IDLE: begin
               // Any valid in IDLE means the granted channel sees ready,
               // so a handshake happens exactly when any_req is high.
               if (any_req) begin
                  op_a       <= req_a_v[gnt_id];
                  op_b       <= req_b_v[gnt_id];
                  id_q       <= gnt_id;
                  last_grant <= gnt_id;
                  state      <= MUL;
               end
            end
            MUL: begin
               prod_q <= mul_p;
               state  <= RESP;
            end
            RESP: begin
               if (rsp_take) begin
                  op_count_q <= sat_inc(op_count_q);
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb
//   Directed self-checking bench for mul_share_arb. Inputs are driven and
//   outputs sampled on the falling clock edge.
module tb_mul_share_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp_product;
   logic        busy;
   logic [15:0] op_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_cnt;

   always #5 clk = ~clk;

   mul_share_arb #(.FIRST_CH(1'b0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .rsp0_valid  (rsp0_valid),
      .rsp0_ready  (rsp0_ready),
      .rsp1_valid  (rsp1_valid),
      .rsp1_ready  (rsp1_ready),
      .rsp_product (rsp_product),
      .busy        (busy),
      .op_count    (op_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input bit ch, input logic v, input logic [15:0] a, input logic [15:0] b);
      if (ch) begin
         req1_valid = v; req1_a = a; req1_b = b;
      end else begin
         req0_valid = v; req0_a = a; req0_b = b;
      end
   endtask

   // Called just after a falling edge with the DUT in IDLE and the other
   // channel quiet; runs one full accept/multiply/respond transaction.
   task automatic run_op(input bit ch, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_p, input string tag);
      if (ch) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      drive_req(ch, 1'b1, a, b);
      #1;
      check({tag, "_req_ready"}, 32'(ch ? req1_ready : req0_ready), 32'd1);
      @(negedge clk);
      // Operands change after acceptance; the captured pair must not.
      drive_req(ch, 1'b0, ~a, ~b);
      check({tag, "_mul_busy"}, 32'(busy), 32'd1);
      check({tag, "_mul_novalid"}, 32'(rsp0_valid | rsp1_valid), 32'd0);
      @(negedge clk);
      check({tag, "_rsp_valid"}, 32'(ch ? rsp1_valid : rsp0_valid), 32'd1);
      check({tag, "_rsp_other"}, 32'(ch ? rsp0_valid : rsp1_valid), 32'd0);
      check({tag, "_product"}, rsp_product, exp_p);
      @(negedge clk);
      exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
      check({tag, "_count"}, 32'(op_count), 32'(exp_cnt));
      check({tag, "_idle"}, 32'(busy), 32'd0);
      $display("txn %s ch%0d a=%04h b=%04h product=%08h count=%04h",
               tag, ch, a, b, exp_p, op_count);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      exp_cnt = '0;

      // ---- reset state ----
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
      check("rst_product", rsp_product, 32'd0);
      check("rst_count", 32'(op_count), 32'd0);
      check("rst_ready_idle", 32'({req1_ready, req0_ready}), 32'd0);
      req0_valid = 1'b1;
      #1;
      check("rst_ready0_valid", 32'(req0_ready), 32'd1);
      check("rst_ready1_valid", 32'(req1_ready), 32'd0);
      req0_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- basic signed products ----
      run_op(1'b0, 16'h0003, 16'hFFFE, 32'hFFFF_FFFA, "ch0_3xm2");
      run_op(1'b1, 16'h8000, 16'h8000, 32'h4000_0000, "ch1_minxmin");
      run_op(1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000, "ch1_maxxmin");
      run_op(1'b0, 16'hFFFF, 16'hFFFF, 32'h0000_0001, "ch0_m1xm1");
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;

      // ---- contention from reset: ch0, ch1, ch0 ----
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      drive_req(1'b0, 1'b1, 16'd5, 16'd7);
      drive_req(1'b1, 1'b1, 16'hFFFC, 16'd6);
      #1;
      check("arb1_ready0", 32'(req0_ready), 32'd1);
      check("arb1_ready1", 32'(req1_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("arb1_rsp0", 32'(rsp0_valid), 32'd1);
      check("arb1_rsp1", 32'(rsp1_valid), 32'd0);
      check("arb1_product", rsp_product, 32'h0000_0023);
      @(negedge clk);
      check("arb2_ready1", 32'(req1_ready), 32'd1);
      check("arb2_ready0", 32'(req0_ready), 32'd0);
      check("arb2_count", 32'(op_count), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("arb2_rsp1", 32'(rsp1_valid), 32'd1);
      check("arb2_rsp0", 32'(rsp0_valid), 32'd0);
      check("arb2_product", rsp_product, 32'hFFFF_FFE8);
      @(negedge clk);
      check("arb3_ready0", 32'(req0_ready), 32'd1);
      check("arb3_ready1", 32'(req1_ready), 32'd0);
      check("arb3_count", 32'(op_count), 32'd2);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      check("arb3_rsp0", 32'(rsp0_valid), 32'd1);
      check("arb3_rsp1", 32'(rsp1_valid), 32'd0);
      check("arb3_product", rsp_product, 32'h0000_0023);
      @(negedge clk);
      check("arb3_count", 32'(op_count), 32'd3);
      $display("txn contention grants ch0,ch1,ch0 count=%04h", op_count);
      exp_cnt = 16'd3;

      // ---- backpressure: rsp0_ready low for 5 cycles ----
      rsp0_ready = 1'b0; rsp1_ready = 1'b1;
      drive_req(1'b0, 1'b1, 16'hFFFD, 16'hFFFB);
      @(negedge clk);
      req0_valid = 1'b0;
      drive_req(1'b1, 1'b1, 16'd1, 16'd1);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("hold_rsp0_valid", 32'(rsp0_valid), 32'd1);
         check("hold_rsp1_valid", 32'(rsp1_valid), 32'd0);
         check("hold_product", rsp_product, 32'h0000_000F);
         check("hold_busy", 32'(busy), 32'd1);
         check("hold_req_ready", 32'({req1_ready, req0_ready}), 32'd0);
         @(negedge clk);
      end
      req1_valid = 1'b0;
      rsp0_ready = 1'b1;
      @(negedge clk);
      exp_cnt = 16'd4;
      check("hold_done_valid", 32'(rsp0_valid), 32'd0);
      check("hold_done_count", 32'(op_count), 32'(exp_cnt));
      check("hold_done_busy", 32'(busy), 32'd0);
      $display("txn backpressure ch0 product=%08h count=%04h", rsp_product, op_count);

      // ---- reset during MUL abandons the transaction ----
      rsp0_ready = 1'b0; rsp1_ready = 1'b1;
      drive_req(1'b1, 1'b1, 16'd2, 16'd3);
      @(negedge clk);
      req1_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
      check("mrst_product", rsp_product, 32'd0);
      check("mrst_count", 32'(op_count), 32'd0);
      check("mrst_req_ready", 32'({req1_ready, req0_ready}), 32'd0);
      exp_cnt = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("mrst_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
         check("mrst_idle", 32'(busy), 32'd0);
      end
      $display("txn reset-in-MUL abandoned count=%04h", op_count);

      // ---- counter saturation ----
      force dut.op_count_q = 16'hFFFE;
      #1;
      release dut.op_count_q;
      #1;
      check("sat_preload", 32'(op_count), 32'h0000_FFFE);
      exp_cnt = 16'hFFFE;
      run_op(1'b0, 16'd2, 16'd3, 32'h0000_0006, "sat1");
      run_op(1'b1, 16'hFFFF, 16'd2, 32'hFFFF_FFFE, "sat2");
      run_op(1'b0, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, "sat3");
      check("sat_final", 32'(op_count), 32'h0000_FFFF);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
